// File: rtl/grid_tile_renderer.sv
// Double-buffered tile-grid renderer: DrawX/DrawY -> registered 4:4:4 RGB, 2-cycle latency.
// Optional macro GRID_LINES_EN overlays LINE_RGB on the first row/column of every cell.
module grid_tile_renderer #(
  parameter int unsigned COLS      = 10,
  parameter int unsigned ROWS      = 18,
  parameter int unsigned CELL_LOG2 = 4,
  parameter int unsigned ORIGIN_X  = 240,
  parameter int unsigned ORIGIN_Y  = 96,
  parameter logic [11:0] BG_RGB    = 12'h000,
  parameter logic [11:0] LINE_RGB  = 12'h444,
  localparam int unsigned CW       = $clog2(COLS),
  localparam int unsigned RW       = $clog2(ROWS)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          frame_start,
  input  logic          wr_en,
  input  logic [CW-1:0] wr_col,
  input  logic [RW-1:0] wr_row,
  input  logic [2:0]    wr_color,
  input  logic          clear_req,
  input  logic          commit_req,
  output logic          busy,
  output logic          commit_pend,
  output logic          commit_done,
  output logic [3:0]    Red,
  output logic [3:0]    Green,
  output logic [3:0]    Blue
);

  localparam int unsigned NCELLS = COLS * ROWS;
  localparam int unsigned AW     = $clog2(NCELLS);

  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + (COLS << CELL_LOG2));
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + (ROWS << CELL_LOG2));

  typedef enum logic [1:0] {StInit, StIdle, StClear, StPend} state_e;

  state_e        st_q, st_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          commit_lat_q, commit_lat_d;
  logic          front_q, front_d;
  logic          last_cell;

  assign last_cell = (cnt_q == AW'(NCELLS - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st_q         <= StInit;
      cnt_q        <= '0;
      commit_lat_q <= 1'b0;
      front_q      <= 1'b0;
    end else begin
      st_q         <= st_d;
      cnt_q        <= cnt_d;
      commit_lat_q <= commit_lat_d;
      front_q      <= front_d;
    end
  end

  always_comb begin
    st_d         = st_q;
    cnt_d        = cnt_q;
    commit_lat_d = commit_lat_q;
    front_d      = front_q;
    commit_done  = 1'b0;
    unique case (st_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (last_cell) begin
          cnt_d = '0;
          st_d  = StIdle;
        end
      end
      StIdle: begin
        if (clear_req) begin
          st_d         = StClear;
          commit_lat_d = commit_req;
        end else if (commit_req) begin
          st_d = StPend;
        end
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (commit_req) commit_lat_d = 1'b1;
        if (last_cell) begin
          cnt_d        = '0;
          commit_lat_d = 1'b0;
          st_d         = (commit_lat_q || commit_req) ? StPend : StIdle;
        end
      end
      StPend: begin
        // A clear arriving with the swap targets the new back buffer; nothing stays pending.
        if (frame_start) begin
          front_d     = ~front_q;
          commit_done = 1'b1;
          st_d        = clear_req ? StClear : StIdle;
        end else if (clear_req) begin
          st_d         = StClear;
          commit_lat_d = 1'b1;
        end
      end
      default: st_d = StInit;
    endcase
  end

  assign busy        = (st_q == StInit) || (st_q == StClear);
  assign commit_pend = (st_q == StPend) || ((st_q == StClear) && commit_lat_q);

  // Cell storage: two reset-less buffers, front selected by front_q
  logic [2:0]    mem0 [NCELLS];
  logic [2:0]    mem1 [NCELLS];
  logic          we0, we1, wr_ok;
  logic [AW-1:0] waddr, wr_idx;
  logic [2:0]    wdata;

  assign wr_ok  = ((st_q == StIdle) || (st_q == StPend)) && wr_en &&
                  ({1'b0, wr_col} < (CW + 1)'(COLS)) && ({1'b0, wr_row} < (RW + 1)'(ROWS));
  assign wr_idx = AW'(wr_row) * AW'(COLS) + AW'(wr_col);

  always_comb begin
    we0   = 1'b0;
    we1   = 1'b0;
    waddr = wr_idx;
    wdata = wr_color;
    if (st_q == StInit) begin
      we0   = 1'b1;
      we1   = 1'b1;
      waddr = cnt_q;
      wdata = '0;
    end else if (st_q == StClear) begin
      we0   = front_q;
      we1   = ~front_q;
      waddr = cnt_q;
      wdata = '0;
    end else if (wr_ok) begin
      // Back buffer is the one not shown; a same-cycle swap makes this write visible.
      we0 = front_q;
      we1 = ~front_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (we0) mem0[waddr] <= wdata;
    if (we1) mem1[waddr] <= wdata;
  end

  // Stage 1: grid hit test and cell coordinates
  logic [10:0]   px, py, dx, dy, cx, cy;
  logic          in_grid_d, in_grid_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  assign px        = {1'b0, DrawX};
  assign py        = {1'b0, DrawY};
  assign in_grid_d = (px >= X_LO) && (px < X_HI) && (py >= Y_LO) && (py < Y_HI);
  assign dx        = px - X_LO;
  assign dy        = py - Y_LO;
  assign cx        = dx >> CELL_LOG2;
  assign cy        = dy >> CELL_LOG2;

  logic unused_bits;
  assign unused_bits = ^{cx[10:CW], cy[10:RW]};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_grid_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
    end else begin
      in_grid_q <= in_grid_d;
      col_q     <= cx[CW-1:0];
      row_q     <= cy[RW-1:0];
    end
  end

`ifdef GRID_LINES_EN
  logic [CELL_LOG2-1:0] subx_q, suby_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      subx_q <= '0;
      suby_q <= '0;
    end else begin
      subx_q <= dx[CELL_LOG2-1:0];
      suby_q <= dy[CELL_LOG2-1:0];
    end
  end
`endif

  // Stage 2: front-buffer read, palette, output register
  function automatic logic [11:0] palette(input logic [2:0] code);
    logic [11:0] rgb;
    unique case (code)
      3'd0:    rgb = BG_RGB;
      3'd1:    rgb = 12'hF00;
      3'd2:    rgb = 12'h0F0;
      3'd3:    rgb = 12'h00F;
      3'd4:    rgb = 12'hFF0;
      3'd5:    rgb = 12'hF0F;
      3'd6:    rgb = 12'hF70;
      default: rgb = 12'hF47;
    endcase
    return rgb;
  endfunction

  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_code;
  logic [11:0]   rgb_d, rgb_q;

  assign rd_addr = in_grid_q ? (AW'(row_q) * AW'(COLS) + AW'(col_q)) : '0;
  assign rd_code = front_q ? mem1[rd_addr] : mem0[rd_addr];

  always_comb begin
    rgb_d = palette(rd_code);
    if (!in_grid_q || (st_q == StInit)) begin
      // Buffers hold garbage until INIT completes
      rgb_d = BG_RGB;
    end
`ifdef GRID_LINES_EN
    else if ((subx_q == '0) || (suby_q == '0)) begin
      rgb_d = LINE_RGB;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rgb_q <= '0;
    else          rgb_q <= rgb_d;
  end

  assign Red   = rgb_q[11:8];
  assign Green = rgb_q[7:4];
  assign Blue  = rgb_q[3:0];

endmodule

// File: tb/tb_grid_tile_renderer.sv
// Scoreboard bench for grid_tile_renderer: pixel expectations queued at drive time,
// popped two clocks later; control outputs checked directly.
module tb_grid_tile_renderer;

`ifdef GRID_LINES_EN
  localparam bit LINES = 1'b1;
`else
  localparam bit LINES = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       frame_start = 0, wr_en = 0, clear_req = 0, commit_req = 0;
  logic [3:0] wr_col = '0;
  logic [4:0] wr_row = '0;
  logic [2:0] wr_color = '0;
  logic       busy, commit_pend, commit_done;
  logic [3:0] Red, Green, Blue;

  always #5 Clk = ~Clk;

  grid_tile_renderer dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .wr_color    (wr_color),
    .clear_req   (clear_req),
    .commit_req  (commit_req),
    .busy        (busy),
    .commit_pend (commit_pend),
    .commit_done (commit_done),
    .Red         (Red),
    .Green       (Green),
    .Blue        (Blue)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          vld;
    logic [11:0] rgb;
    string       tag;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: compare the pixel driven two cycles ago, clear pulses, drive a new pixel.
  task automatic cyc(input int x, input int y, input bit vld, input logic [11:0] rgb,
                     input string tag);
    exp_t e;
    @(negedge Clk);
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      if (e.vld) check(e.tag, {Red, Green, Blue}, e.rgb);
    end
    wr_en       = 1'b0;
    clear_req   = 1'b0;
    commit_req  = 1'b0;
    frame_start = 1'b0;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    e.vld = vld;
    e.rgb = rgb;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 1'b0, 12'h000, "");
  endtask

  task automatic pix(input int x, input int y, input logic [11:0] rgb, input string tag);
    cyc(x, y, 1'b1, rgb, tag);
  endtask

  task automatic write_cell(input int c, input int r, input int color);
    idle(1);
    wr_en    = 1'b1;
    wr_col   = 4'(c);
    wr_row   = 5'(r);
    wr_color = 3'(color);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 400) begin
      n++;
      idle(1);
    end
  endtask

  int n;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    #2 Reset_n = 1'b0;
    idle(3);
    #1;
    check("rst_rgb", {Red, Green, Blue}, 12'h000);
    check("rst_busy", busy, 1'b1);
    check("rst_pend", commit_pend, 1'b0);
    check("rst_done", commit_done, 1'b0);

    // 1: INIT lasts 180 cycles, display stays background throughout
    idle(1);
    Reset_n = 1'b1;
    #1;
    n = 0;
    while (busy && n < 400) begin
      n++;
      if (n % 2 == 0) pix(241 + 16 * (n % 10), 97 + 16 * (n % 18), 12'h000, "t1_init_pix");
      else            pix(n % 640, n % 480, 12'h000, "t1_init_any");
    end
    check("t1_init_len", n, 180);
    pix(241, 97, 12'h000, "t1_zeroed");
    idle(2);

    // 2: single cell, commit, swap
    write_cell(0, 0, 1);
    idle(1);
    commit_req = 1'b1;
    idle(1);
    #1 check("t2_pend", commit_pend, 1'b1);
    frame_start = 1'b1;
    #1 check("t2_done", commit_done, 1'b1);
    idle(1);
    #1 check("t2_done_pulse", commit_done, 1'b0);
    check("t2_pend_clr", commit_pend, 1'b0);
    pix(240, 96, LINES ? 12'h444 : 12'hF00, "t2_origin");
    pix(239, 96, 12'h000, "t2_left");
    pix(241, 97, 12'hF00, "t2_inner");
    pix(240, 95, 12'h000, "t2_above");
    idle(2);

    // 3: uncommitted write invisible; frame_start outside PEND does nothing
    write_cell(9, 17, 7);
    idle(1);
    frame_start = 1'b1;
    #1 check("t3_fs_idle", commit_done, 1'b0);
    pix(399, 383, 12'h000, "t3_nocommit");
    pix(400, 383, 12'h000, "t3_xedge");
    pix(399, 384, 12'h000, "t3_yedge");
    idle(2);
    commit_req = 1'b1;
    idle(1);
    frame_start = 1'b1;
    idle(1);
    pix(399, 383, 12'hF47, "t3_committed");
    pix(241, 97, 12'h000, "t3_old_front");
    idle(2);

    // 4: clear + commit together, write during busy dropped
    clear_req  = 1'b1;
    commit_req = 1'b1;
    idle(1);
    #1 check("t4_busy", busy, 1'b1);
    wr_en = 1'b1; wr_col = 4'd5; wr_row = 5'd5; wr_color = 3'd2;
    wait_idle(n);
    check("t4_clear_len", n, 180);
    #1 check("t4_pend", commit_pend, 1'b1);
    check("t4_no_done", commit_done, 1'b0);
    pix(399, 383, 12'hF47, "t4_front_kept");
    idle(2);
    frame_start = 1'b1;
    #1 check("t4_done", commit_done, 1'b1);
    idle(1);
    pix(241, 97, 12'h000, "t4_cleared");
    pix(321, 177, 12'h000, "t4_dropped");
    idle(2);

    // 5: out-of-range writes, repeated commit, write coinciding with the swap
    write_cell(10, 0, 5);
    write_cell(15, 0, 5);
    write_cell(0, 18, 5);
    write_cell(9, 31, 5);
    write_cell(1, 0, 4);
    idle(1);
    commit_req = 1'b1;
    idle(1);
    #1 check("t5_pend", commit_pend, 1'b1);
    commit_req = 1'b1;
    idle(1);
    #1 check("t5_pend2", commit_pend, 1'b1);
    frame_start = 1'b1;
    wr_en = 1'b1; wr_col = 4'd2; wr_row = 5'd0; wr_color = 3'd6;
    #1 check("t5_done", commit_done, 1'b1);
    idle(1);
    #1 check("t5_pend_clr", commit_pend, 1'b0);
    frame_start = 1'b1;
    #1 check("t5_single_done", commit_done, 1'b0);
    pix(241, 113, 12'h000, "t5_col10");
    pix(321, 113, 12'h000, "t5_col15");
    pix(289, 193, 12'h000, "t5_row31");
    pix(257, 97, 12'hFF0, "t5_valid");
    pix(273, 97, 12'hF70, "t5_swap_write");
    pix(399, 383, 12'hF47, "t5_carried");
    idle(2);

    // 6: grid-line overlay (solid cell when disabled)
    pix(256, 100, LINES ? 12'h444 : 12'hFF0, "t6_line");
    pix(257, 101, 12'hFF0, "t6_interior");
    pix(258, 96, LINES ? 12'h444 : 12'hFF0, "t6_hline");
    idle(2);

    // Reset in the middle of a clear restarts INIT
    clear_req = 1'b1;
    idle(10);
    Reset_n = 1'b0;
    #1;
    check("rr_busy", busy, 1'b1);
    check("rr_rgb", {Red, Green, Blue}, 12'h000);
    check("rr_pend", commit_pend, 1'b0);
    sb.delete();
    idle(2);
    Reset_n = 1'b1;
    #1;
    wait_idle(n);
    check("rr_init_len", n, 180);
    pix(257, 97, 12'h000, "rr_reinit");
    pix(399, 383, 12'h000, "rr_reinit2");
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
